// File: rtl/conv_pkg.sv
// Shared types and helpers for the 5x5 convolution datapath.
//   IMAGE_MAX_W        : largest supported image width/height
//   DIM_W              : width of dimension/count fields
//   image_dim_t        : dimension / raster-coordinate type
//   conv_sched_state_t : window scheduler FSM states
//   kernel_pos_t       : per-centre neighbour validity, MSB first
//                        {w2,w1,e1,e2,n2,n1,s1,s2}, 1 = neighbour inside the image
//   kernel_pos()       : decode of kernel_pos_t from centre (ox,oy) and image W,H
package conv_pkg;

    localparam int IMAGE_MAX_W = 4096;
    localparam int DIM_W       = $clog2(IMAGE_MAX_W) + 1;

    typedef logic [DIM_W-1:0] image_dim_t;

    localparam image_dim_t DIM_ONE = image_dim_t'(1);
    localparam image_dim_t DIM_TWO = image_dim_t'(2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } conv_sched_state_t;

    typedef struct packed {
        logic w2;
        logic w1;
        logic e1;
        logic e2;
        logic n2;
        logic n1;
        logic s1;
        logic s2;
    } kernel_pos_t;

    // East/south tests are written as "coord + k < dim" so that nothing
    // underflows for small W or H (e.g. H=1 gives s1=s2=0).
    function automatic kernel_pos_t kernel_pos(input image_dim_t ox, input image_dim_t oy,
                                               input image_dim_t w,  input image_dim_t h);
        kernel_pos_t p;
        p.w2 = (ox >= DIM_TWO);
        p.w1 = (ox >= DIM_ONE);
        p.e1 = ((ox + DIM_ONE) < w);
        p.e2 = ((ox + DIM_TWO) < w);
        p.n2 = (oy >= DIM_TWO);
        p.n1 = (oy >= DIM_ONE);
        p.s1 = ((oy + DIM_ONE) < h);
        p.s2 = ((oy + DIM_TWO) < h);
        return p;
    endfunction

endpackage

// File: rtl/conv_raster_cnt.sv
// Raster x/y counter used for both the input and the output raster.
//   clk, rst : clock, synchronous active-high reset
//   clear    : zero both coordinates (start of frame)
//   inc      : advance one position; x wraps at w-1 to 0 and bumps y
//   w, h     : image width / height
//   x, y     : current coordinate (y keeps counting past h-1 while the
//              window is drained, so it is a full DIM_W wide)
//   last     : current position is (w-1, h-1)
module conv_raster_cnt
    import conv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    input  logic [DIM_W-1:0] w,
    input  logic [DIM_W-1:0] h,
    output logic [DIM_W-2:0] x,
    output logic [DIM_W-1:0] y,
    output logic             last
);

    localparam logic [DIM_W-2:0] X_ONE = 1;

    logic [DIM_W-2:0] x_reg;
    logic [DIM_W-1:0] y_reg;
    logic             x_last;

    assign x_last = ({1'b0, x_reg} == (w - DIM_ONE));
    assign last   = x_last && (y_reg == (h - DIM_ONE));
    assign x      = x_reg;
    assign y      = y_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            x_reg <= '0;
            y_reg <= '0;
        end else if (inc) begin
            if (x_last) begin
                x_reg <= '0;
                y_reg <= y_reg + DIM_ONE;
            end else begin
                x_reg <= x_reg + X_ONE;
            end
        end
    end

endmodule

// File: rtl/conv_window_sched.sv
// Sequencing controller for the 5x5 convolution datapath.
// Accepts the raster pixel stream, drives line-buffer pushes/column address
// and issues one kernel window per output centre, lagging the input by
// 2 rows + 2 columns; drains the window with padding pushes at end of frame.
//   clk, rst         : clock, synchronous active-high reset
//   cfg_w, cfg_h     : image width (3..4096) / height (1..4096), sampled on start
//   start            : begin frame, ignored while busy
//   busy, done       : frame in progress / 1-cycle pulse after last kernel issue
//   s_valid, s_ready : pixel ingress handshake
//   lb_push, lb_pad  : line buffers shift one pixel / pushed pixel is padding
//   lb_col           : column address of the pushed pixel
//   k_valid, k_ready : kernel-issue handshake
//   k_pos            : kernel_pos_t neighbour-validity of the current centre
//   k_sof, k_eol     : current centre is (0,0) / last column
module conv_window_sched
    import conv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [DIM_W-1:0] cfg_w,
    input  logic [DIM_W-1:0] cfg_h,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             lb_push,
    output logic             lb_pad,
    output logic [DIM_W-2:0] lb_col,
    output logic             k_valid,
    input  logic             k_ready,
    output logic [7:0]       k_pos,
    output logic             k_sof,
    output logic             k_eol
);

    localparam int CNT_IN  = 0;
    localparam int CNT_OUT = 1;

    conv_sched_state_t state_reg, state_next;
    logic [DIM_W-1:0]  w_reg;
    logic [DIM_W-1:0]  h_reg;
    logic              done_reg;

    logic              frame_clear;
    logic              fire;
    logic              out_issue;
    logic              fill_done;
    logic [1:0]        cnt_inc;
    logic [DIM_W-2:0]  cnt_x [2];
    logic [DIM_W-1:0]  cnt_y [2];
    logic [1:0]        cnt_last;
    kernel_pos_t       pos_dec;

    // Input raster counter (every push, real or pad) and output raster
    // counter (every issued centre).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            conv_raster_cnt u_cnt (
                .clk   (clk),
                .rst   (rst),
                .clear (frame_clear),
                .inc   (cnt_inc[gi]),
                .w     (w_reg),
                .h     (h_reg),
                .x     (cnt_x[gi]),
                .y     (cnt_y[gi]),
                .last  (cnt_last[gi])
            );
        end
    endgenerate

    // The fill count equals the input raster position iy*W+ix while in FILL,
    // so the accept that brings it to 2W+2 is the one at (ix,iy) = (1,2).
    assign fill_done = (cnt_y[CNT_IN] == DIM_TWO) &&
                       (cnt_x[CNT_IN] == (DIM_W-1)'(1));

    assign fire        = s_valid && k_ready;
    assign frame_clear = (state_reg == IDLE) && start;
    assign cnt_inc     = {out_issue, lb_push};

    always_comb begin
        state_next = state_reg;
        s_ready    = 1'b0;
        k_valid    = 1'b0;
        lb_push    = 1'b0;
        out_issue  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = FILL;
            end
            FILL: begin
                s_ready = 1'b1;
                lb_push = s_valid;
                if (s_valid) begin
                    // Last input takes priority so tiny frames skip RUN.
                    if (cnt_last[CNT_IN])  state_next = FLUSH;
                    else if (fill_done)    state_next = RUN;
                end
            end
            RUN: begin
                s_ready   = k_ready;
                k_valid   = s_valid;
                lb_push   = fire;
                out_issue = fire;
                if (fire && cnt_last[CNT_IN]) state_next = FLUSH;
            end
            FLUSH: begin
                k_valid   = 1'b1;
                lb_push   = k_ready;
                out_issue = k_ready;
                if (k_ready && cnt_last[CNT_OUT]) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            w_reg     <= '0;
            h_reg     <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_reg == FLUSH) && k_ready && cnt_last[CNT_OUT];
            if (frame_clear) begin
                w_reg <= cfg_w;
                h_reg <= cfg_h;
            end
        end
    end

    assign pos_dec = kernel_pos({1'b0, cnt_x[CNT_OUT]}, cnt_y[CNT_OUT], w_reg, h_reg);

    assign busy   = (state_reg != IDLE);
    assign done   = done_reg;
    assign lb_pad = (state_reg == FLUSH);
    assign lb_col = cnt_x[CNT_IN];
    assign k_pos  = busy ? pos_dec : 8'h00;
    assign k_sof  = busy && (cnt_x[CNT_OUT] == '0) && (cnt_y[CNT_OUT] == '0);
    assign k_eol  = busy && ({1'b0, cnt_x[CNT_OUT]} == (w_reg - DIM_ONE));

endmodule

// File: tb/tb_conv_window_sched.sv
module tb_conv_window_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] cfg_w = '0;
    logic [12:0] cfg_h = '0;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic        k_ready = 1'b0;
    logic        busy, done, s_ready, lb_push, lb_pad, k_valid, k_sof, k_eol;
    logic [11:0] lb_col;
    logic [7:0]  k_pos;

    int n_cmp  = 0;
    int n_fail = 0;

    // per-frame observations
    int fill_c, run_c, pad_c, kf_c, eol_c, done_c, cyc_c;
    logic [7:0] cap_pos [3];
    logic [7:0] pos_first, pos_last;

    conv_window_sched dut (
        .clk     (clk),
        .rst     (rst),
        .cfg_w   (cfg_w),
        .cfg_h   (cfg_h),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .lb_push (lb_push),
        .lb_pad  (lb_pad),
        .lb_col  (lb_col),
        .k_valid (k_valid),
        .k_ready (k_ready),
        .k_pos   (k_pos),
        .k_sof   (k_sof),
        .k_eol   (k_eol)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // {w2,w1,e1,e2,n2,n1,s1,s2}
    function automatic logic [7:0] exp_pos(input int ox, input int oy, input int w, input int h);
        return {ox >= 2, ox >= 1, ox <= w - 2, ox <= w - 3,
                oy >= 2, oy >= 1, oy <= h - 2, oy <= h - 3};
    endfunction

    // Runs one frame from start to done. Call just after a rising edge.
    // gaps: random s_valid/k_ready bubbles (s_valid held until accepted).
    task automatic run_frame(input int w, input int h, input bit gaps, input bit hold_start);
        int   ex_ox, ex_oy, ex_col;
        bit   stalled, pending, finished;
        logic [7:0] held_pos;
        fill_c = 0; run_c = 0; pad_c = 0; kf_c = 0; eol_c = 0; done_c = 0; cyc_c = 0;
        ex_ox = 0; ex_oy = 0; ex_col = 0;
        stalled = 1'b0; pending = 1'b0; finished = 1'b0; held_pos = '0;
        cfg_w = 13'(w); cfg_h = 13'(h);
        s_valid = 1'b0; k_ready = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = hold_start;
        chk("busy_after_start", 32'(busy), 32'd1);
        for (int cyc = 0; cyc < 40000 && !finished; cyc++) begin
            if (!pending) s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            k_ready = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk);
            cyc_c++;
            if (done) begin
                done_c++;
                finished = 1'b1;
            end else begin
                if (stalled) begin
                    chk("stall_k_valid", 32'(k_valid), 32'd1);
                    chk("stall_k_pos", 32'(k_pos), 32'(held_pos));
                end
                if (lb_push) begin
                    chk("lb_col", 32'(lb_col), 32'(ex_col));
                    ex_col = (ex_col + 1) % w;
                    if (lb_pad)       pad_c++;
                    else if (k_valid) run_c++;
                    else              fill_c++;
                end
                if (k_valid && k_ready) begin
                    chk("k_pos", 32'(k_pos), 32'(exp_pos(ex_ox, ex_oy, w, h)));
                    chk("k_sof", 32'(k_sof), 32'(ex_ox == 0 && ex_oy == 0));
                    chk("k_eol", 32'(k_eol), 32'(ex_ox == w - 1));
                    if (kf_c < 3) cap_pos[kf_c] = k_pos;
                    if (ex_ox == 0 && ex_oy == 0) pos_first = k_pos;
                    if (ex_ox == w - 1 && ex_oy == h - 1) pos_last = k_pos;
                    if (k_eol) eol_c++;
                    kf_c++;
                    if (ex_ox == w - 1) begin
                        ex_ox = 0;
                        ex_oy++;
                    end else begin
                        ex_ox++;
                    end
                end
                stalled  = k_valid && !k_ready;
                held_pos = k_pos;
                pending  = s_valid && !s_ready;
            end
            @(posedge clk); #1;
        end
        if (!finished) chk("frame_timeout", 32'd0, 32'd1);
        start = 1'b0; s_valid = 1'b0; k_ready = 1'b0;
        chk("centres", 32'(kf_c), 32'(w * h));
        chk("real_pushes", 32'(fill_c + run_c), 32'(w * h));
        chk("eol_count", 32'(eol_c), 32'(h));
        chk("done_pulses", 32'(done_c), 32'd1);
        $display("frame %0dx%0d gaps=%0d: fill=%0d run=%0d pad=%0d centres=%0d done=%0d cycles=%0d",
                 w, h, gaps, fill_c, run_c, pad_c, kf_c, done_c, cyc_c);
    endtask

    initial begin
        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_lb_push", 32'(lb_push), 32'd0);
        chk("rst_lb_pad", 32'(lb_pad), 32'd0);
        chk("rst_k_valid", 32'(k_valid), 32'd0);
        chk("rst_lb_col", 32'(lb_col), 32'd0);
        chk("rst_k_pos", 32'(k_pos), 32'd0);
        chk("rst_k_sof", 32'(k_sof), 32'd0);
        chk("rst_k_eol", 32'(k_eol), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // ---- 1: W=8 H=6 streaming ----
        run_frame(8, 6, 1'b0, 1'b0);
        chk("t1_fill", 32'(fill_c), 32'd18);
        chk("t1_run", 32'(run_c), 32'd30);
        chk("t1_pad", 32'(pad_c), 32'd18);
        chk("t1_kfires", 32'(kf_c), 32'd48);
        chk("t1_idle_after", 32'(busy), 32'd0);

        // ---- 2: W=3 H=1, FILL straight to FLUSH ----
        run_frame(3, 1, 1'b0, 1'b0);
        chk("t2_fill", 32'(fill_c), 32'd3);
        chk("t2_run", 32'(run_c), 32'd0);
        chk("t2_pad", 32'(pad_c), 32'd3);
        chk("t2_pos0", 32'(cap_pos[0]), 32'h30);
        chk("t2_pos1", 32'(cap_pos[1]), 32'h60);
        chk("t2_pos2", 32'(cap_pos[2]), 32'hC0);

        // ---- 3: W=5 H=5 with bubbles on both sides ----
        run_frame(5, 5, 1'b1, 1'b0);
        chk("t3_fill", 32'(fill_c), 32'd12);
        chk("t3_run", 32'(run_c), 32'd13);
        chk("t3_pad", 32'(pad_c), 32'd12);

        // ---- 4: W=16 H=16 corners ----
        run_frame(16, 16, 1'b0, 1'b0);
        chk("t4_pos_00", 32'(pos_first), 32'h33);
        chk("t4_pos_1515", 32'(pos_last), 32'hCC);
        chk("t4_pad", 32'(pad_c), 32'd34);

        // ---- 5: reset mid-RUN of W=8 H=8, then a clean frame ----
        cfg_w = 13'd8; cfg_h = 13'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; s_valid = 1'b1; k_ready = 1'b1;
        repeat (24) @(posedge clk);
        #1;
        chk("t5_mid_k_valid", 32'(k_valid), 32'd1);
        chk("t5_mid_lb_pad", 32'(lb_pad), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_s_ready", 32'(s_ready), 32'd0);
        chk("t5_k_valid", 32'(k_valid), 32'd0);
        chk("t5_lb_push", 32'(lb_push), 32'd0);
        @(posedge clk); #1;
        chk("t5_no_done", 32'(done), 32'd0);
        s_valid = 1'b0; k_ready = 1'b0;
        run_frame(8, 8, 1'b0, 1'b0);
        chk("t5_fill", 32'(fill_c), 32'd18);
        chk("t5_run", 32'(run_c), 32'd46);
        chk("t5_pad", 32'(pad_c), 32'd18);

        // ---- 6: W=4096 H=2, start held high throughout ----
        run_frame(4096, 2, 1'b0, 1'b1);
        chk("t6_fill", 32'(fill_c), 32'd8192);
        chk("t6_run", 32'(run_c), 32'd0);
        chk("t6_pad", 32'(pad_c), 32'd8192);
        // start was still high in the done cycle, so a new frame began
        chk("t6_start_on_done", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_busy_after_rst", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
